sha256_msg_schedule: RTL and testbench

Message-schedule expander for the SHA-256 core, directly upstream of the ALU-based compression datapath. It accepts one 512-bit block as 16 big-endian 32-bit words and emits the 64-word schedule W[0..63] one word per handshake. The compression round consumes each W[t] as an ALU ADD operand. A 16-entry circular buffer and an internal sigma0/sigma1/add path generate W[16..63] on the fly.

---
 rtl/sha256_msg_schedule_if.sv | 21 ++
 rtl/sha256_msg_schedule.sv | 110 +++++++++++
 tb/tb_sha256_msg_schedule.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/sha256_msg_schedule_if.sv
// sha256_msg_schedule_if: block-load and schedule-output handshake bundle.
// The master side drives start, the words and w_ready; the slave side is the expander.
interface sha256_msg_schedule_if #(
   parameter int WORD_W = 32,
   parameter int IDX_W  = 6
);
   logic              start;
   logic              in_valid;
   logic              in_ready;
   logic [WORD_W-1:0] in_word;
   logic              w_valid;
   logic              w_ready;
   logic [WORD_W-1:0] w_word;
   logic [IDX_W-1:0]  w_index;
   logic              busy;
   logic              done;
   modport master (output start, in_valid, in_word, w_ready,
                   input  in_ready, w_valid, w_word, w_index, busy, done);
   modport slave  (input  start, in_valid, in_word, w_ready,
                   output in_ready, w_valid, w_word, w_index, busy, done);
endinterface

// File: rtl/sha256_msg_schedule.sv
// sha256_msg_schedule: expands one 16-word block into W[0..63] from a 16-entry circular buffer.
// Define SHA256_SCHED_STREAM_EN to pass W[0..15] straight through while loading.
module sha256_msg_schedule #(
   parameter int WORD_W = 32,
   parameter int ROUNDS = 64
) (
   input logic                 clock,
   input logic                 reset_n,
   sha256_msg_schedule_if.slave bus
);
   localparam int IDX_W = $clog2(ROUNDS);
   localparam logic [IDX_W-1:0] T_LAST = IDX_W'(ROUNDS - 1);
   localparam logic [IDX_W-1:0] T_GEN  = IDX_W'(16);

   typedef enum logic [1:0] {IDLE, LOAD, EMIT, DONE} state_t;

   state_t            state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic [IDX_W-1:0]  t_q, t_d;
   logic [WORD_W-1:0] mem_q [16];
   logic [WORD_W-1:0] mem_d [16];
   logic [3:0]        t4;
   logic [WORD_W-1:0] gen_w;
   logic              in_rdy;

   function automatic logic [31:0] s0(input logic [31:0] x);
      return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
   endfunction

   function automatic logic [31:0] s1(input logic [31:0] x);
      return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
   endfunction

   // buf[t%16] still holds W[t-16] until the transfer overwrites it with W[t]
   always_comb begin
      t4    = t_q[3:0];
      gen_w = s1(mem_q[t4 - 4'd2]) + mem_q[t4 - 4'd7] + s0(mem_q[t4 - 4'd15]) + mem_q[t4];
   end

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      t_d          = t_q;
      mem_d        = mem_q;
      bus.w_valid  = 1'b0;
      bus.w_word   = (t_q < T_GEN) ? mem_q[t4] : gen_w;
      bus.w_index  = t_q;
      bus.done     = 1'b0;
      bus.busy     = (state_q != IDLE);
`ifdef SHA256_SCHED_STREAM_EN
      in_rdy       = (state_q == LOAD) && bus.w_ready;
`else
      in_rdy       = (state_q == LOAD);
`endif
      bus.in_ready = in_rdy;
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               state_d = LOAD;
               cnt_d   = '0;
            end
         end
         LOAD: begin
`ifdef SHA256_SCHED_STREAM_EN
            bus.w_valid = bus.in_valid;
            bus.w_word  = bus.in_word;
            bus.w_index = IDX_W'(cnt_q);
`endif
            if (bus.in_valid && in_rdy) begin
               mem_d[cnt_q] = bus.in_word;
               cnt_d        = cnt_q + 4'd1;
               if (cnt_q == 4'd15) begin
                  state_d = EMIT;
`ifdef SHA256_SCHED_STREAM_EN
                  t_d     = T_GEN;
`else
                  t_d     = '0;
`endif
               end
            end
         end
         EMIT: begin
            bus.w_valid = 1'b1;
            if (bus.w_ready) begin
               if (t_q >= T_GEN) mem_d[t4] = gen_w;
               t_d = t_q + IDX_W'(1);
               if (t_q == T_LAST) state_d = DONE;
            end
         end
         DONE: begin
            bus.done = 1'b1;
            state_d  = IDLE;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         t_q     <= '0;
         mem_q   <= '{default: '0};
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         t_q     <= t_d;
         mem_q   <= mem_d;
      end
   end
endmodule

// File: tb/tb_sha256_msg_schedule.sv
// tb_sha256_msg_schedule: directed vectors for the SHA-256 schedule expander,
// compared against a straight 64-entry reference schedule and hand-computed words.
module tb_sha256_msg_schedule;
   typedef logic [31:0] blk_t [16];
   typedef logic [31:0] sch_t [64];
   typedef struct {
      string       name;
      bit          zero_blk;
      int          t;
      logic [31:0] w;
   } vec_t;

   logic clock = 1'b0;
   logic reset_n = 1'b0;
   always #5 clock = ~clock;

   sha256_msg_schedule_if bus ();
   sha256_msg_schedule dut (.clock(clock), .reset_n(reset_n), .bus(bus));

   int checks = 0;
   int errors = 0;
   int busy_bad = 0;
   int n_got = 0;
   int n_done = 0;
   logic [31:0] got_w [64];
   int          got_i [64];
   sch_t abc_got, zero_got, ref_abc, ref_zero;
   blk_t abc_blk, zero_blk;
   vec_t vt [10];

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   function automatic sch_t ref_sched(input blk_t m);
      sch_t w;
      for (int t = 0; t < 16; t++) w[t] = m[t];
      for (int t = 16; t < 64; t++)
         w[t] = (rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10)) + w[t-7]
              + (rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-16];
      return w;
   endfunction

   // monitor: records transfers and checks that stalled outputs stay put
   logic        stall_prev = 1'b0;
   logic [31:0] prev_w;
   logic [5:0]  prev_i;
   always @(negedge clock) begin
      #2;
      if (reset_n) begin
         if (stall_prev) begin
            check("hold_valid", 32'(bus.w_valid), 32'd1);
            check("hold_word", bus.w_word, prev_w);
            check("hold_index", 32'(bus.w_index), 32'(prev_i));
         end
         stall_prev = bus.w_valid && !bus.w_ready;
         prev_w     = bus.w_word;
         prev_i     = bus.w_index;
         if (bus.w_valid && bus.w_ready) begin
            if (n_got < 64) begin
               got_w[n_got] = bus.w_word;
               got_i[n_got] = int'(bus.w_index);
            end
            n_got++;
         end
         if (bus.done) n_done++;
      end else begin
         stall_prev = 1'b0;
      end
   end

   // called just after a negedge with the DUT idle
   task automatic load(input blk_t m, input bit gap);
      int i = 0;
      int cyc = 0;
      n_got    = 0;
      n_done   = 0;
      busy_bad = 0;
      bus.start = 1'b1;
      @(negedge clock);
      bus.start = 1'b0;
      while (i < 16 && cyc < 100) begin
         bus.in_valid = gap ? (cyc % 2 == 0) : 1'b1;
         bus.in_word  = bus.in_valid ? m[i] : 32'hdead_beef;
         #1;
         if (!bus.busy) busy_bad++;
         if (bus.in_valid && bus.in_ready) i++;
         @(negedge clock);
         cyc++;
      end
      bus.in_valid = 1'b0;
      bus.in_word  = 32'h0;
      check("load_accepted", i, 16);
   endtask

   task automatic emit(input int stall_at, input int stall_len, input int rst_at, input bit poke,
                       output bit aborted, output int stalled);
      int cyc = 0;
      bit fin = 1'b0;
      aborted = 1'b0;
      stalled = 0;
      while (!fin && cyc < 300) begin
         bus.start = 1'b0;
         #1;
`ifndef SHA256_SCHED_STREAM_EN
         if (cyc == 0) begin
            check("first_valid", 32'(bus.w_valid), 32'd1);
            check("first_index", 32'(bus.w_index), 32'd0);
         end
`endif
         if (bus.done) begin
            fin = 1'b1;
            if (poke) bus.start = 1'b1;
         end else begin
            if (!bus.busy) busy_bad++;
            if (bus.w_valid && int'(bus.w_index) == rst_at) begin
               reset_n = 1'b0;
               aborted = 1'b1;
               fin     = 1'b1;
            end
            bus.w_ready = !(bus.w_valid && int'(bus.w_index) == stall_at && stalled < stall_len);
            if (!bus.w_ready) stalled++;
            if (poke && bus.w_valid && bus.w_index == 6'd40) bus.start = 1'b1;
         end
         @(negedge clock);
         cyc++;
      end
      bus.start   = 1'b0;
      bus.w_ready = 1'b1;
      if (!fin) check("emit_timeout", 32'd0, 32'd1);
   endtask

   task automatic run(input blk_t m, input bit gap, input int stall_at, input int stall_len,
                      input bit poke, input sch_t exp, output int stalled);
      bit ab;
      int idle_bad = 0;
      load(m, gap);
      emit(stall_at, stall_len, -1, poke, ab, stalled);
      #1;
      check("done_one_cycle", 32'(bus.done), 32'd0);
      check("busy_after_done", 32'(bus.busy), 32'd0);
      for (int k = 0; k < 3; k++) begin
         @(negedge clock);
         #1;
         if (bus.busy || bus.in_ready || bus.w_valid) idle_bad++;
      end
      @(negedge clock);
      check("stays_idle", idle_bad, 0);
      check("busy_during_block", busy_bad, 0);
      check("done_pulses", n_done, 1);
      check("word_count", n_got, 64);
      for (int t = 0; t < 64; t++) begin
         check($sformatf("w[%0d]", t), got_w[t], exp[t]);
         check($sformatf("idx[%0d]", t), got_i[t], t);
      end
   endtask

   initial begin
      int st;
      bit ab;
      int done_before;
      abc_blk  = '{default: 32'h0};
      abc_blk[0]  = 32'h6162_6380;
      abc_blk[15] = 32'h0000_0018;
      zero_blk = '{default: 32'h0};
      ref_abc  = ref_sched(abc_blk);
      ref_zero = ref_sched(zero_blk);
      vt[0] = '{"abc_w0",  1'b0, 0,  32'h6162_6380};
      vt[1] = '{"abc_w1",  1'b0, 1,  32'h0000_0000};
      vt[2] = '{"abc_w14", 1'b0, 14, 32'h0000_0000};
      vt[3] = '{"abc_w15", 1'b0, 15, 32'h0000_0018};
      vt[4] = '{"abc_w16", 1'b0, 16, 32'h6162_6380};
      vt[5] = '{"abc_w17", 1'b0, 17, 32'h000f_0000};
      vt[6] = '{"abc_w18", 1'b0, 18, 32'h7da8_6405};
      vt[7] = '{"zero_w0", 1'b1, 0,  32'h0000_0000};
      vt[8] = '{"zero_w16", 1'b1, 16, 32'h0000_0000};
      vt[9] = '{"zero_w63", 1'b1, 63, 32'h0000_0000};

      bus.start = 1'b0; bus.in_valid = 1'b0; bus.in_word = 32'h0; bus.w_ready = 1'b1;
      repeat (2) @(negedge clock);
      #1;
      check("rst_in_ready", 32'(bus.in_ready), 32'd0);
      check("rst_w_valid", 32'(bus.w_valid), 32'd0);
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_done", 32'(bus.done), 32'd0);
      check("rst_index", 32'(bus.w_index), 32'd0);
      reset_n = 1'b1;
      @(negedge clock);

      // in_valid while idle must not be consumed or start anything
      bus.in_valid = 1'b1;
      @(negedge clock);
      #1;
      check("idle_in_ready", 32'(bus.in_ready), 32'd0);
      check("idle_busy", 32'(bus.busy), 32'd0);
      @(negedge clock);
      bus.in_valid = 1'b0;

      run(abc_blk, 1'b0, -1, 0, 1'b0, ref_abc, st);
      abc_got = got_w;
      run(zero_blk, 1'b0, -1, 0, 1'b0, ref_zero, st);
      zero_got = got_w;
      for (int v = 0; v < 10; v++)
         check(vt[v].name, vt[v].zero_blk ? zero_got[vt[v].t] : abc_got[vt[v].t], vt[v].w);

      run(abc_blk, 1'b0, 20, 5, 1'b0, ref_abc, st);
      check("stall_cycles", st, 5);

      run(abc_blk, 1'b1, -1, 0, 1'b0, ref_abc, st);

      load(abc_blk, 1'b0);
      emit(-1, 0, 30, 1'b0, ab, st);
      check("reset_hit", 32'(ab), 32'd1);
      #1;
      check("post_rst_w_valid", 32'(bus.w_valid), 32'd0);
      check("post_rst_busy", 32'(bus.busy), 32'd0);
      reset_n = 1'b1;
      done_before = n_done;
      repeat (4) @(negedge clock);
      check("post_rst_no_done", n_done, done_before);
      run(abc_blk, 1'b0, -1, 0, 1'b0, ref_abc, st);

      run(abc_blk, 1'b0, -1, 0, 1'b1, ref_abc, st);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
